// File: rtl/legv8_alu_sequencer_if.sv
// Request/response channel bundle for the LEGv8 ALU sequencer.
// master = requester side, slave = sequencer side.
interface legv8_alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic        req_setflags;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;

  modport master (
    output req_valid, req_op, req_setflags,
    output req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_setflags,
    input  req_a, req_b, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_result, rsp_flags
  );
endinterface

// File: rtl/legv8_alu_sequencer.sv
// Multi-cycle op sequencer in front of the LEGv8 64-bit ALU; MUL is shift-and-add.
// Optional LEGV8_MUL_EARLY_EXIT_EN: MUL leaves as soon as the multiplier is zero.
module legv8_alu_sequencer #(
  parameter int MUL_ITERS = 64
) (
  input  logic        clk,
  input  logic        rst,
  legv8_alu_sequencer_if.slave bus,
  output logic [3:0]  flags,
  output logic [63:0] alu_A,
  output logic [63:0] alu_B,
  output logic [4:0]  alu_FS,
  output logic        alu_C0,
  input  logic [63:0] alu_F,
  input  logic [3:0]  alu_status
);

  typedef enum logic [1:0] {
    IDLE, EXEC, MUL, RESP
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b111;
  localparam logic [6:0] ITERS = 7'(MUL_ITERS);

  state_t      state;
  logic [2:0]  op_q;
  logic        sf_q;
  logic [63:0] a_q, b_q;
  logic [63:0] acc, mcand, mplier;
  logic [6:0]  cnt;
  logic [63:0] result;
  logic [3:0]  rflags;
  logic        mul_skip;

  assign bus.req_ready  = (state == IDLE) & ~rst;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_result = result;
  assign bus.rsp_flags  = rflags;

  // Early-exit test: remaining partial products are all zero
  always_comb begin
`ifdef LEGV8_MUL_EARLY_EXIT_EN
    mul_skip = (mplier == 64'd0);
`else
    mul_skip = 1'b0;
`endif
  end

  // ALU operand and function drive, decoded from the current state
  always_comb begin
    alu_A  = 64'd0;
    alu_B  = 64'd0;
    alu_FS = 5'b00000;
    alu_C0 = 1'b0;
    unique case (state)
      EXEC: begin
        alu_A = a_q;
        alu_B = b_q;
        case (op_q)
          3'b000:  alu_FS = 5'b00000;
          3'b001:  alu_FS = 5'b00100;
          3'b010:  alu_FS = 5'b01000;
          3'b011:  alu_FS = 5'b01100;
          3'b100:  alu_FS = 5'b10000;
          3'b101:  alu_FS = 5'b10100;
          3'b110:  begin
            alu_FS = 5'b01001;
            alu_C0 = 1'b1;
          end
          default: alu_FS = 5'b01000;
        endcase
      end
      MUL: begin
        alu_A  = acc;
        alu_B  = mplier[0] ? mcand : 64'd0;
        alu_FS = 5'b01000;
      end
      default: ;
    endcase
  end

  // Sequencer FSM, operand latches, MUL datapath and flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 3'd0;
      sf_q   <= 1'b0;
      a_q    <= 64'd0;
      b_q    <= 64'd0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 64'd0;
      cnt    <= 7'd0;
      result <= 64'd0;
      rflags <= 4'd0;
      flags  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            sf_q   <= bus.req_setflags;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            acc    <= 64'd0;
            mcand  <= bus.req_a;
            mplier <= bus.req_b;
            cnt    <= 7'd0;
            state  <= (bus.req_op == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          result <= alu_F;
          rflags <= alu_status;
          state  <= RESP;
        end
        MUL: begin
          if (mul_skip) begin
            result <= acc;
            rflags <= 4'd0;
            state  <= RESP;
          end else begin
            acc    <= alu_F;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 7'd1;
            if (cnt + 7'd1 == ITERS) begin
              result <= alu_F;
              rflags <= 4'd0;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            if (sf_q && op_q != OP_MUL)
              flags <= rflags;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_alu_sequencer.sv
// Scoreboard bench for legv8_alu_sequencer with a behavioural LEGv8 ALU attached.
// Expected results come from direct op semantics, not from the ALU model.
module tb_legv8_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  flags;
  logic [63:0] alu_A, alu_B, alu_F;
  logic [4:0]  alu_FS;
  logic        alu_C0;
  logic [3:0]  alu_status;

  legv8_alu_sequencer_if bus();

  legv8_alu_sequencer #(.MUL_ITERS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flags      (flags),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_FS     (alu_FS),
    .alu_C0     (alu_C0),
    .alu_F      (alu_F),
    .alu_status (alu_status)
  );

  always #5 clk = ~clk;

  logic [63:0] aa, bb;
  logic [64:0] sum;
  // Behavioural LEGv8 ALU
  always_comb begin
    aa  = alu_FS[1] ? ~alu_A : alu_A;
    bb  = alu_FS[0] ? ~alu_B : alu_B;
    sum = {1'b0, aa} + {1'b0, bb} + {64'd0, alu_C0};
    alu_F = 64'd0;
    case (alu_FS[4:2])
      3'd0:    alu_F = aa & bb;
      3'd1:    alu_F = aa | bb;
      3'd2:    alu_F = sum[63:0];
      3'd3:    alu_F = aa ^ bb;
      3'd4:    alu_F = alu_A << alu_B[5:0];
      3'd5:    alu_F = alu_A >> alu_B[5:0];
      default: alu_F = 64'd0;
    endcase
    alu_status = 4'd0;
    alu_status[1] = alu_F[63];
    alu_status[0] = (alu_F == 64'd0);
    if (alu_FS[4:2] == 3'd2) begin
      alu_status[2] = sum[64];
      alu_status[3] = (aa[63] == bb[63]) && (alu_F[63] != aa[63]);
    end
  end

  typedef struct {
    logic [63:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] model_flags = 4'd0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a ^ b;
      3'd4:    return a << b[5:0];
      3'd5:    return a >> b[5:0];
      3'd6:    return a - b;
      default: return a * b;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] r;
    logic [64:0] w;
    logic v, c;
    if (op == 3'd7) return 4'd0;
    r = ref_res(op, a, b);
    v = 1'b0;
    c = 1'b0;
    if (op == 3'd2) begin
      w = {1'b0, a} + {1'b0, b};
      c = w[64];
      v = (a[63] == b[63]) && (r[63] != a[63]);
    end else if (op == 3'd6) begin
      w = {1'b0, a} + {1'b0, ~b} + 65'd1;
      c = w[64];
      v = (a[63] != b[63]) && (r[63] != a[63]);
    end
    return {v, c, r[63], r == 64'd0};
  endfunction

  function automatic logic [5:0] fs_c0(input logic [2:0] op);
    case (op)
      3'd0:    return 6'b00000_0;
      3'd1:    return 6'b00100_0;
      3'd2:    return 6'b01000_0;
      3'd3:    return 6'b01100_0;
      3'd4:    return 6'b10000_0;
      3'd5:    return 6'b10100_0;
      default: return 6'b01001_1;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op,
                                 input logic [63:0] b);
    int h;
    if (op != 3'd7) return 2;
`ifdef LEGV8_MUL_EARLY_EXIT_EN
    if (b == 64'd0) return 2;
    h = 0;
    for (int i = 0; i < 64; i++)
      if (b[i]) h = i;
    return ((h + 2 > 64) ? 64 : h + 2) + 1;
`else
    h = 0;
    return 65 + h;
`endif
  endfunction

  task automatic do_op(input logic [2:0] op, input logic sf,
                       input logic [63:0] a, input logic [63:0] b,
                       input int hold);
    exp_t e;
    int lat;
    logic [63:0] r0;
    logic [3:0]  f0;
    logic [3:0]  old_flags;
    chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_setflags = sf;
    bus.req_a        = a;
    bus.req_b        = b;
    e.r = ref_res(op, a, b);
    e.f = ref_flags(op, a, b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
    if (op != 3'd7) begin
      chk("exec_fs_c0", {58'd0, alu_FS, alu_C0}, {58'd0, fs_c0(op)});
      chk("exec_alu_a", alu_A, a);
    end
    lat = 1;
    while (!bus.rsp_valid && lat < 300) begin
      @(posedge clk);
      #1;
      if (!bus.rsp_valid) lat++;
    end
    if (!bus.rsp_valid) lat = 999;
    else lat++;
    chk("latency", 64'(lat), 64'(exp_lat(op, b)));
    r0 = bus.rsp_result;
    f0 = bus.rsp_flags;
    old_flags = model_flags;
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = i[0];
      bus.req_op    = 3'd1;
      bus.req_a     = 64'hdead;
      bus.req_b     = 64'hbeef;
      @(posedge clk);
      #1;
      chk("hold_result", bus.rsp_result, r0);
      chk("hold_rflags", {60'd0, bus.rsp_flags}, {60'd0, f0});
      chk("hold_ready", {63'd0, bus.req_ready}, 64'd0);
      chk("hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
    end
    bus.req_valid = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_result", bus.rsp_result, e.r);
      chk("rsp_flags", {60'd0, bus.rsp_flags}, {60'd0, e.f});
      if (sf && op != 3'd7) model_flags = e.f;
    end
    chk("flags_pre", {60'd0, flags}, {60'd0, old_flags});
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("flags_post", {60'd0, flags}, {60'd0, model_flags});
    chk("rsp_valid_drop", {63'd0, bus.rsp_valid}, 64'd0);
    chk("req_ready_back", {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic chk_alu_idle(input string tag);
    chk(tag, {alu_A ^ alu_B, 58'd0, alu_FS, alu_C0} , 128'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [2:0]  rop;
    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_op       = 3'd0;
    bus.req_setflags = 1'b0;
    bus.req_a        = 64'd0;
    bus.req_b        = 64'd0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_result", bus.rsp_result, 64'd0);
    chk("rst_rflags", {60'd0, bus.rsp_flags}, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);
    chk("rst_alu_a", alu_A, 64'd0);
    chk("rst_alu_b", alu_B, 64'd0);
    chk("rst_alu_fs", {58'd0, alu_FS, alu_C0}, 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;

    do_op(3'd2, 1'b0, 64'd5, 64'd7, 0);
    do_op(3'd6, 1'b1, 64'd3, 64'd3, 0);
    do_op(3'd7, 1'b1, 64'd6, 64'd7, 0);
    do_op(3'd7, 1'b0, '1, '1, 0);
    do_op(3'd7, 1'b0, 64'h1234_5678, 64'd0, 0);
    do_op(3'd7, 1'b0, 64'h1_0000_0003, 64'h8000_0000_0000_0001, 0);
    do_op(3'd2, 1'b1, 64'h7fff_ffff_ffff_ffff, 64'd1, 0);
    do_op(3'd4, 1'b1, 64'h1, 64'hffff_ffc0_0000_003f, 0);
    do_op(3'd5, 1'b1, 64'h8000_0000_0000_0000, 64'd63, 0);
    do_op(3'd6, 1'b1, 64'd0, 64'd1, 0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      do_op(rop, 1'($urandom_range(0, 1)), ra, rb, 0);
    end
    do_op(3'd7, 1'b0, {$urandom, $urandom}, {32'd0, $urandom}, 0);

    do_op(3'd3, 1'b1, 64'hf0f0, 64'h0ff0, 10);

    do_op(3'd6, 1'b1, 64'd3, 64'd3, 0);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd7;
    bus.req_a     = 64'd6;
    bus.req_b     = '1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mul_busy", {63'd0, bus.req_ready}, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("midrst_flags", {60'd0, flags}, 64'd0);
    chk_alu_idle("midrst_alu");
    rst = 1'b0;
    sb.delete();
    model_flags = 4'd0;
    #1;
    do_op(3'd2, 1'b1, 64'd100, 64'd23, 0);
    chk_alu_idle("idle_alu");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/legv8_alu_sequencer.md
# legv8_alu_sequencer

Multi-cycle operation sequencer that sits in front of the LEGv8 64-bit ALU and drives its FS/C0/A/B operand interface while consuming its F/status outputs. It accepts one operation at a time over a valid/ready request channel. It issues single-cycle ALU ops directly and runs MUL as an iterative shift-and-add loop that uses the ALU adder. It maintains the architectural NZCV flag register for flag-setting ops and returns results on a valid/ready response channel.

## Interface
Parameters:
- `MUL_ITERS`, 64: maximum shift-and-add iterations for MUL (operand width).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  3  op code: 000 AND, 001 ORR, 010 ADD, 011 EOR, 100 LSL, 101 LSR, 110 SUB, 111 MUL.
- `req_setflags`  in  1  update `flags` on completion; ignored for MUL.
- `req_a`, `req_b`  in  64  operands (for LSL/LSR, only `req_b[5:0]` is meaningful).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_result`  out  64  result.
- `rsp_flags`  out  4  {V,C,N,Z} of this op; 4'b0000 for MUL.
- `flags`  out  4  architectural {V,C,N,Z} register.
- `alu_A`, `alu_B`  out  64  ALU operands.
- `alu_FS`  out  5  ALU function select.
- `alu_C0`  out  1  ALU carry-in.
- `alu_F`  in  64  ALU result.
- `alu_status`  in  4  ALU {V,C,N,Z}.

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch op, setflags, A and B. Go to MUL if op=111, otherwise go to EXEC.
- FS/C0 mapping: AND 00000/0, ORR 00100/0, ADD 01000/0, EOR 01100/0, LSL 10000/0, LSR 10100/0, SUB 01001/1.
- EXEC: drive `alu_A`=A, `alu_B`=B and the mapped FS/C0. Capture `alu_F` into the result and `alu_status` into `rsp_flags`. Go to RESP.
- MUL registers: acc (init 0), mcand (init A), mplier (init B), 7-bit iteration count (init 0).
- Each MUL cycle drives `alu_A`=acc, `alu_B`= (mplier[0] ? mcand : 0), FS=01000, C0=0. It then updates acc←`alu_F`, mcand←mcand<<1, mplier←mplier>>1, count+1.
- MUL exits to RESP after the cycle where count reaches `MUL_ITERS`. The result is acc modulo 2^64 (low 64 bits, signed/unsigned agnostic). `rsp_flags`=0.
- RESP: `rsp_valid`=1 and the result is held stable until `rsp_ready`. On `rsp_valid & rsp_ready`: if setflags and op≠MUL, `flags`←`rsp_flags`. Then return to IDLE.
- `alu_status` is taken verbatim, with no correction of any flag.
- In IDLE and RESP: `alu_A`=0, `alu_B`=0, `alu_FS`=0, `alu_C0`=0.

## Timing
- Reset values: `req_ready`=0 during the reset cycle and 1 after it. `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0, `flags`=0, ALU drives 0, state=IDLE.
- Reset mid-EXEC, mid-MUL or in RESP drops the in-flight op; `flags` is cleared.
- Non-MUL op accepted in cycle t: EXEC in t+1, `rsp_valid` in t+2. The minimum issue interval is 3 cycles.
- MUL accepted in t (without the macro): MUL state occupies t+1..t+64, `rsp_valid` in t+65.
- `req_ready` is low from acceptance until the cycle after the response handshake. There is no back-to-back overlap.
- `rsp_ready` held low: the sequencer stays in RESP indefinitely with outputs constant.
- `flags` changes exactly on the rising edge following the response handshake.
- `req_valid` asserted while not ready is ignored; the request is not latched.

## Configuration
- `LEGV8_MUL_EARLY_EXIT_EN` defined: at the start of each MUL cycle, if mplier==0, the sequencer skips the update and goes to RESP. The result is unchanged, since the remaining additions are zero.
  - MUL by 0 spends 1 cycle in MUL.
  - MUL by B spends (index of B's highest set bit + 2) cycles in MUL, capped at `MUL_ITERS`.
- Not defined: MUL always takes exactly `MUL_ITERS` cycles in the MUL state.

## Test plan
- ADD A=5, B=7, setflags=0 -> `rsp_result`=12. `rsp_valid` 2 cycles after accept. `flags` stays 0000.
- SUB A=3, B=3, setflags=1, team ALU attached -> `rsp_result`=0. `rsp_flags`=`flags`=4'b0101 after the handshake. `alu_FS`=01001 and `alu_C0`=1 during EXEC.
- MUL A=6, B=7 -> 42 with `rsp_flags`=0 and `flags` unchanged. `rsp_valid` 65 cycles after accept without the macro, 5 cycles after accept with `LEGV8_MUL_EARLY_EXIT_EN`.
- MUL A=0xFFFF_FFFF_FFFF_FFFF, B=0xFFFF_FFFF_FFFF_FFFF -> 1 (wrap). MUL by B=0 -> 0, 2 cycles after accept with the macro.
- `rsp_ready` held low for 10 cycles after `rsp_valid` -> result, `rsp_flags` and `req_ready`=0 are stable. `req_valid` pulses during that time are not latched.
- `rst` asserted at MUL cycle 20 -> next cycle `rsp_valid`=0, `flags`=0, ALU drives 0. A new ADD then completes normally.
